// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, BEQ resolution,
// and the EX/MEM pipeline register feeding the memory stage.
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWrite_E,
  input  logic            ALUSrc_E,
  input  logic            MemWrite_E,
  input  logic            ResultSrc_E,
  input  logic            Branch_E,
  input  logic [2:0]      ALUControl_E,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PC_E,
  input  logic [XLEN-1:0] PCPlus4_E,
  input  logic [4:0]      Rd_E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] Result_W,
  input  logic            Stall_M,
  input  logic            Flush_M,
  output logic            PCSrc_E,
  output logic [XLEN-1:0] PCTarget_E,
  output logic            RegWrite_M,
  output logic            MemWrite_M,
  output logic            ResultSrc_M,
  output logic [XLEN-1:0] ALUResult_M,
  output logic [XLEN-1:0] WriteData_M,
  output logic [XLEN-1:0] PCPlus4_M,
  output logic [4:0]      Rd_M
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] wd;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_y;
  logic            lt;

  // Forward from ALUResult_M taps the register output, never alu_y
  always_comb begin
    src_a = RD1_E;
    unique case (ForwardA_E)
      2'b01:   src_a = Result_W;
      2'b10:   src_a = ALUResult_M;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    wd = RD2_E;
    unique case (ForwardB_E)
      2'b01:   wd = Result_W;
      2'b10:   wd = ALUResult_M;
      default: wd = RD2_E;
    endcase
  end

  assign src_b = ALUSrc_E ? Imm_Ext_E : wd;
  assign lt    = $signed(src_a) < $signed(src_b);

  always_comb begin
    alu_y = '0;
    unique case (ALUControl_E)
      3'b000:  alu_y = src_a + src_b;
      3'b001:  alu_y = src_a - src_b;
      3'b010:  alu_y = src_a & src_b;
      3'b011:  alu_y = src_a | src_b;
      3'b101:  alu_y = {{(XLEN-1){1'b0}}, lt};
      default: alu_y = '0;
    endcase
  end

  assign PCSrc_E    = Branch_E & (alu_y == '0);
  assign PCTarget_E = PC_E + Imm_Ext_E;

  always_ff @(posedge clk) begin
    if (rst || Flush_M) begin
      RegWrite_M  <= 1'b0;
      MemWrite_M  <= 1'b0;
      ResultSrc_M <= 1'b0;
      ALUResult_M <= '0;
      WriteData_M <= '0;
      PCPlus4_M   <= '0;
      Rd_M        <= '0;
    end else if (!Stall_M) begin
      RegWrite_M  <= RegWrite_E;
      MemWrite_M  <= MemWrite_E;
      ResultSrc_M <= ResultSrc_E;
      ALUResult_M <= alu_y;
      WriteData_M <= wd;
      PCPlus4_M   <= PCPlus4_E;
      Rd_M        <= Rd_E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push
// expected EX/MEM contents; a monitor pops one per clock.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_E, ALUSrc_E, MemWrite_E;
  logic        ResultSrc_E, Branch_E;
  logic [2:0]  ALUControl_E;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E;
  logic [31:0] PC_E, PCPlus4_E, Result_W;
  logic [4:0]  Rd_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        Stall_M, Flush_M;
  logic        PCSrc_E;
  logic [31:0] PCTarget_E;
  logic        RegWrite_M, MemWrite_M, ResultSrc_M;
  logic [31:0] ALUResult_M, WriteData_M, PCPlus4_M;
  logic [4:0]  Rd_M;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        rs;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } m_t;

  typedef struct {
    string name;
    m_t    v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .RegWrite_E(RegWrite_E), .ALUSrc_E(ALUSrc_E),
    .MemWrite_E(MemWrite_E), .ResultSrc_E(ResultSrc_E),
    .Branch_E(Branch_E), .ALUControl_E(ALUControl_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .PC_E(PC_E), .PCPlus4_E(PCPlus4_E), .Rd_E(Rd_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .Result_W(Result_W), .Stall_M(Stall_M), .Flush_M(Flush_M),
    .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
    .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M),
    .ResultSrc_M(ResultSrc_M), .ALUResult_M(ALUResult_M),
    .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M),
    .Rd_M(Rd_M)
  );

  // Monitor: the register presents a new bundle every clock
  always @(posedge clk) begin
    exp_t e;
    m_t   a;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = '{RegWrite_M, MemWrite_M, ResultSrc_M,
            ALUResult_M, WriteData_M, PCPlus4_M, Rd_M};
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.name, a, e.v);
      end
    end
  end

  function automatic m_t mk(logic rw, logic mw, logic rs,
                            logic [31:0] alu, logic [31:0] wd,
                            logic [31:0] pc4, logic [4:0] rd);
    return '{rw, mw, rs, alu, wd, pc4, rd};
  endfunction

  m_t last;

  task automatic tick(string name, m_t v);
    exp_t e;
    e.name = name;
    e.v    = v;
    q.push_back(e);
    last = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op(logic [2:0] c, logic [31:0] a, logic [31:0] b);
    ALUControl_E = c;
    RD1_E        = a;
    RD2_E        = b;
  endtask

  task automatic chk_c(string name, logic src, logic [31:0] tgt);
    #1;
    checks++;
    if (PCSrc_E !== src || PCTarget_E !== tgt) begin
      errors++;
      $display("FAIL %s: got PCSrc=%b PCTarget=%h, expected %b %h",
               name, PCSrc_E, PCTarget_E, src, tgt);
    end
  endtask

  initial begin
    rst = 1'b1;
    RegWrite_E = 1'b0; ALUSrc_E = 1'b0; MemWrite_E = 1'b0;
    ResultSrc_E = 1'b0; Branch_E = 1'b1;
    op(3'b001, 32'd3, 32'd3);
    Imm_Ext_E = 32'h10; PC_E = 32'h200; PCPlus4_E = 32'h204;
    Rd_E = 5'd7; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    Result_W = 32'h0; Stall_M = 1'b0; Flush_M = 1'b0;
    RegWrite_E = 1'b1;
    @(negedge clk);
    chk_c("rst_branch_comb", 1'b1, 32'h210);
    tick("reset0", '0);
    tick("reset1", '0);
    rst = 1'b0;
    Branch_E = 1'b0;
    PC_E = 32'h100; PCPlus4_E = 32'h104; Rd_E = 5'd3;

    op(3'b000, 32'd5, 32'd7);
    tick("add", mk(1, 0, 0, 32'd12, 32'd7, 32'h104, 3));
    op(3'b001, 32'd5, 32'd7);
    tick("sub", mk(1, 0, 0, 32'hFFFFFFFE, 32'd7, 32'h104, 3));
    op(3'b101, 32'hFFFFFFFF, 32'd1);
    tick("slt_neg", mk(1, 0, 0, 32'd1, 32'd1, 32'h104, 3));
    op(3'b101, 32'd1, 32'hFFFFFFFF);
    tick("slt_swap", mk(1, 0, 0, 32'd0, 32'hFFFFFFFF, 32'h104, 3));
    op(3'b000, 32'hFFFFFFFF, 32'd1);
    tick("add_wrap", mk(1, 0, 0, 32'd0, 32'd1, 32'h104, 3));
    op(3'b010, 32'hF0F0, 32'hFF00);
    tick("and", mk(1, 0, 0, 32'hF000, 32'hFF00, 32'h104, 3));
    op(3'b011, 32'hF0F0, 32'hFF00);
    tick("or", mk(1, 0, 0, 32'hFFF0, 32'hFF00, 32'h104, 3));
    op(3'b111, 32'hF0F0, 32'hFF00);
    tick("undef_op", mk(1, 0, 0, 32'h0, 32'hFF00, 32'h104, 3));

    Branch_E = 1'b1; Imm_Ext_E = 32'hFFFFFFF8;
    op(3'b001, 32'd9, 32'd9);
    chk_c("beq_taken", 1'b1, 32'hF8);
    tick("beq_taken_m", mk(1, 0, 0, 32'd0, 32'd9, 32'h104, 3));
    op(3'b001, 32'd9, 32'd8);
    chk_c("beq_not_taken", 1'b0, 32'hF8);
    tick("beq_nt_m", mk(1, 0, 0, 32'd1, 32'd8, 32'h104, 3));
    Branch_E = 1'b0;

    ALUSrc_E = 1'b1; MemWrite_E = 1'b1; ResultSrc_E = 1'b1;
    Rd_E = 5'd0; Imm_Ext_E = 32'h20; ForwardA_E = 2'b11;
    op(3'b000, 32'h10, 32'h99);
    tick("imm_x0_fwd11", mk(1, 1, 1, 32'h30, 32'h99, 32'h104, 0));
    ALUSrc_E = 1'b0; MemWrite_E = 1'b0; ResultSrc_E = 1'b0;
    ForwardA_E = 2'b00; Rd_E = 5'd4; PCPlus4_E = 32'h108;

    op(3'b000, 32'h30, 32'h10);
    tick("pre_fwd", mk(1, 0, 0, 32'h40, 32'h10, 32'h108, 4));
    ForwardA_E = 2'b10; ForwardB_E = 2'b01; Result_W = 32'h10;
    op(3'b000, 32'h1234, 32'h5678);
    tick("fwd", mk(1, 0, 0, 32'h50, 32'h10, 32'h108, 4));
    ForwardA_E = 2'b00; ForwardB_E = 2'b00;

    Stall_M = 1'b1; PCPlus4_E = 32'h10C; Rd_E = 5'd9;
    op(3'b011, 32'h1, 32'h2);
    for (int i = 0; i < 3; i++) tick("stall", last);
    Flush_M = 1'b1;
    tick("stall_flush", '0);
    Stall_M = 1'b0; Flush_M = 1'b0;
    tick("resume", mk(1, 0, 0, 32'h3, 32'h2, 32'h10C, 9));
    Flush_M = 1'b1;
    tick("flush", '0);
    Flush_M = 1'b0; Rd_E = 5'd10;
    op(3'b000, 32'h100, 32'h1);
    tick("after_flush", mk(1, 0, 0, 32'h101, 32'h1, 32'h10C, 10));
    rst = 1'b1;
    tick("mid_reset", '0);
    rst = 1'b0;

    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
